// File: rtl/free_list.sv
// free_list: circular FIFO of free physical tags for a 4-wide rename stage with flush recovery
module free_list #(
    parameter int PREG_NUM = 64,
    parameter int TAG_W    = 6,
    parameter int DEPTH    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_alloc_valid,
    input  logic [3:0]       i_alloc_req,
    output logic             o_alloc_ready,
    output logic [TAG_W-1:0] o_alloc_prd0,
    output logic [TAG_W-1:0] o_alloc_prd1,
    output logic [TAG_W-1:0] o_alloc_prd2,
    output logic [TAG_W-1:0] o_alloc_prd3,
    input  logic [3:0]       i_rel_valid,
    input  logic [TAG_W-1:0] i_rel_prd0,
    input  logic [TAG_W-1:0] i_rel_prd1,
    input  logic [TAG_W-1:0] i_rel_prd2,
    input  logic [TAG_W-1:0] i_rel_prd3,
    input  logic             i_flush,
    output logic [TAG_W-1:0] o_free_count,
    output logic             o_empty,
    output logic             o_overflow_err
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_spec_head, r_arch_head, r_tail;
    logic             r_overflow;
    logic [2:0]       w_n_alloc, w_n_rel;
    logic [2:0]       w_a_rank [4];
    logic [2:0]       w_r_rank [4];
    logic [TAG_W-1:0] w_rel_prd [4];
    logic [TAG_W-1:0] w_alloc_prd [4];
    logic [PW-1:0]    w_free_count, w_n_rel_eff;
    logic [PW:0]      w_after;
    logic             w_ready, w_fire, w_over;

    assign w_rel_prd[0] = i_rel_prd0;
    assign w_rel_prd[1] = i_rel_prd1;
    assign w_rel_prd[2] = i_rel_prd2;
    assign w_rel_prd[3] = i_rel_prd3;

    // rank of each slot among the set bits below it, plus total popcounts
    always_comb begin
        w_n_alloc = '0;
        w_n_rel   = '0;
        for (int i = 0; i < 4; i++) begin
            w_a_rank[i] = w_n_alloc;
            w_r_rank[i] = w_n_rel;
            w_n_alloc   = w_n_alloc + {2'b0, i_alloc_req[i]};
            w_n_rel     = w_n_rel + {2'b0, i_rel_valid[i]};
        end
    end

    assign w_free_count = r_tail - r_spec_head;
    assign w_ready      = (w_free_count >= PW'(w_n_alloc)) && !i_flush;
    assign w_fire       = i_alloc_valid && w_ready;
    // tags handed out this cycle vacate their slots for this edge's release writes
    assign w_after      = {1'b0, w_free_count} - (w_fire ? (PW+1)'(w_n_alloc) : '0) + (PW+1)'(w_n_rel);
    assign w_over       = w_after > (PW+1)'(DEPTH);
    assign w_n_rel_eff  = w_over ? '0 : PW'(w_n_rel);

    // compacted tag grant read straight from the speculative head
    always_comb begin
        for (int i = 0; i < 4; i++)
            w_alloc_prd[i] = i_alloc_req[i] ? r_mem[r_spec_head[IW-1:0] + IW'(w_a_rank[i])] : '0;
    end

    assign o_alloc_ready  = w_ready;
    assign o_alloc_prd0   = w_alloc_prd[0];
    assign o_alloc_prd1   = w_alloc_prd[1];
    assign o_alloc_prd2   = w_alloc_prd[2];
    assign o_alloc_prd3   = w_alloc_prd[3];
    assign o_free_count   = TAG_W'(w_free_count);
    assign o_empty        = w_free_count == '0;
    assign o_overflow_err = r_overflow;

    // tag storage, pointer updates, flush recovery and sticky overflow
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= TAG_W'(PREG_NUM - DEPTH + i);
            r_spec_head <= '0;
            r_arch_head <= '0;
            r_tail      <= PW'(DEPTH);
            r_overflow  <= 1'b0;
        end else begin
            if (w_over) begin
                r_overflow <= 1'b1;
            end else begin
                for (int j = 0; j < 4; j++)
                    if (i_rel_valid[j])
                        r_mem[r_tail[IW-1:0] + IW'(w_r_rank[j])] <= w_rel_prd[j];
                r_tail      <= r_tail + w_n_rel_eff;
                r_arch_head <= r_arch_head + w_n_rel_eff;
            end
            if (i_flush)
                r_spec_head <= r_arch_head + w_n_rel_eff;
            else if (w_fire)
                r_spec_head <= r_spec_head + PW'(w_n_alloc);
        end
    end
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: scoreboard bench for free_list with directed, hand-computed vectors
module tb_free_list;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_valid, alloc_ready, flush, empty, overflow_err;
    logic [3:0] alloc_req, rel_valid;
    logic [5:0] prd0, prd1, prd2, prd3, rel0, rel1, rel2, rel3, free_count;
    logic [5:0] prd_o [4];

    typedef struct {
        string       name;
        bit          chk_rdy;
        bit          rdy;
        bit          chk_prd;
        logic [23:0] prd;
        bit          chk_st;
        logic [5:0]  fc;
        bit          ovf;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    free_list dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_alloc_valid(alloc_valid), .i_alloc_req(alloc_req),
        .o_alloc_ready(alloc_ready), .o_alloc_prd0(prd0), .o_alloc_prd1(prd1),
        .o_alloc_prd2(prd2), .o_alloc_prd3(prd3), .i_rel_valid(rel_valid),
        .i_rel_prd0(rel0), .i_rel_prd1(rel1), .i_rel_prd2(rel2), .i_rel_prd3(rel3),
        .i_flush(flush), .o_free_count(free_count), .o_empty(empty), .o_overflow_err(overflow_err)
    );

    assign prd_o[0] = prd0;
    assign prd_o[1] = prd1;
    assign prd_o[2] = prd2;
    assign prd_o[3] = prd3;

    function automatic logic [23:0] p4(input int a3, input int a2, input int a1, input int a0);
        return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endfunction

    task automatic chk(input string n, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", n, act, req);
        end
    endtask

    task automatic exp_alloc(input string n, input bit rdy, input logic [23:0] prd, input bit chk_prd);
        exp_t e;
        e.name = n; e.chk_rdy = 1'b1; e.rdy = rdy; e.chk_prd = chk_prd; e.prd = prd;
        e.chk_st = 1'b0; e.fc = '0; e.ovf = 1'b0;
        q.push_back(e);
    endtask

    task automatic exp_state(input string n, input int fc, input bit ovf);
        exp_t e;
        e.name = n; e.chk_rdy = 1'b0; e.rdy = 1'b0; e.chk_prd = 1'b0; e.prd = '0;
        e.chk_st = 1'b1; e.fc = 6'(fc); e.ovf = ovf;
        q.push_back(e);
    endtask

    task automatic drive(input logic av, input logic [3:0] rq, input logic [3:0] rv,
                         input logic [23:0] rt, input logic fl);
        alloc_valid = av; alloc_req = rq; rel_valid = rv; flush = fl;
        rel0 = rt[5:0]; rel1 = rt[11:6]; rel2 = rt[17:12]; rel3 = rt[23:18];
    endtask

    task automatic idle();
        drive(1'b0, 4'b0, 4'b0, 24'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        step();
        rst_n = 1'b1;
    endtask

    // monitor: compare every pending expectation against the outputs mid-cycle
    always @(negedge clk) begin
        while (q.size() > 0) begin
            m_e = q.pop_front();
            if (m_e.chk_rdy)
                chk({m_e.name, "_ready"}, int'(alloc_ready), int'(m_e.rdy));
            if (m_e.chk_prd)
                for (int s = 0; s < 4; s++)
                    chk($sformatf("%s_prd%0d", m_e.name, s), int'(prd_o[s]), int'(m_e.prd[s*6 +: 6]));
            if (m_e.chk_st) begin
                chk({m_e.name, "_free_count"}, int'(free_count), int'(m_e.fc));
                chk({m_e.name, "_empty"}, int'(empty), int'(m_e.fc == 6'd0));
                chk({m_e.name, "_overflow"}, int'(overflow_err), int'(m_e.ovf));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;

        exp_state("reset", 32, 0);
        exp_alloc("idle", 1, 24'b0, 1);
        step();
        drive(1, 4'b1011, 4'b0, 24'b0, 0);
        exp_alloc("a1011", 1, p4(34, 0, 33, 32), 1);
        step();
        idle();
        exp_state("fc29", 29, 0);
        step();
        for (int k = 0; k < 6; k++) begin
            drive(1, 4'b1111, 4'b0, 24'b0, 0);
            exp_alloc("drain", 1, p4(38 + 4*k, 37 + 4*k, 36 + 4*k, 35 + 4*k), 1);
            step();
        end
        drive(1, 4'b0111, 4'b0, 24'b0, 0);
        exp_alloc("a0111", 1, p4(0, 61, 60, 59), 1);
        step();
        drive(1, 4'b0111, 4'b0, 24'b0, 0);
        exp_state("fc2", 2, 0);
        exp_alloc("short", 0, 24'b0, 0);
        step();
        idle();
        exp_state("held", 2, 0);
        step();
        drive(1, 4'b0011, 4'b0, 24'b0, 0);
        exp_alloc("a0011", 1, p4(0, 0, 63, 62), 1);
        step();
        drive(1, 4'b0000, 4'b0, 24'b0, 0);
        exp_state("empty", 0, 0);
        exp_alloc("zero_req", 1, 24'b0, 1);
        step();
        drive(1, 4'b0001, 4'b0101, p4(11, 9, 7, 5), 0);
        exp_alloc("no_bypass", 0, 24'b0, 0);
        step();
        idle();
        exp_state("rel2", 2, 0);
        step();
        drive(1, 4'b0011, 4'b0, 24'b0, 0);
        exp_alloc("rel_tags", 1, p4(0, 0, 9, 5), 1);
        step();
        idle();
        exp_state("empty2", 0, 0);
        step();

        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1, 4'b1111, 4'b1111, p4(3, 2, 1, 0), 0);
            exp_state("wrap", 32, 0);
            exp_alloc("wrap", 1, (k < 8) ? p4(35 + 4*k, 34 + 4*k, 33 + 4*k, 32 + 4*k) : p4(3, 2, 1, 0), 1);
            step();
        end
        idle();
        exp_state("wrap_end", 32, 0);
        step();

        do_reset();
        drive(1, 4'b1111, 4'b0, 24'b0, 0);
        exp_alloc("f_a0", 1, p4(35, 34, 33, 32), 1);
        step();
        drive(1, 4'b1111, 4'b0, 24'b0, 0);
        exp_alloc("f_a1", 1, p4(39, 38, 37, 36), 1);
        step();
        drive(1, 4'b1111, 4'b0111, p4(0, 34, 33, 32), 1);
        exp_alloc("flush_rdy", 0, 24'b0, 0);
        exp_state("pre_flush", 24, 0);
        step();
        idle();
        exp_state("post_flush", 32, 0);
        step();
        drive(1, 4'b0001, 4'b0, 24'b0, 0);
        exp_alloc("flush_head", 1, p4(0, 0, 0, 35), 1);
        step();
        drive(1, 4'b1111, 4'b0, 24'b0, 0);
        exp_alloc("flush_next", 1, p4(39, 38, 37, 36), 1);
        step();

        do_reset();
        drive(0, 4'b0, 4'b0001, p4(0, 0, 0, 7), 0);
        exp_state("ovf_pre", 32, 0);
        step();
        idle();
        exp_state("ovf_set", 32, 1);
        step();
        step();
        step();
        drive(1, 4'b0001, 4'b0, 24'b0, 0);
        exp_state("ovf_sticky", 32, 1);
        exp_alloc("ovf_alloc", 1, p4(0, 0, 0, 32), 1);
        step();
        drive(0, 4'b0, 4'b0001, p4(0, 0, 0, 7), 0);
        exp_state("ovf_fc31", 31, 1);
        step();
        idle();
        exp_state("ovf_rel_ok", 32, 1);
        step();
        rst_n = 1'b0;
        exp_state("async_rst", 32, 0);
        step();
        rst_n = 1'b1;
        exp_state("after_rst", 32, 0);
        step();

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
